// File: rtl/flash_pkg.sv
// flash_pkg: shared FSM states, core-port constants and error read value for the flash arbiter
package flash_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
  localparam logic WB_READ = 1'b0;
  localparam logic WB_WRITE = 1'b1;
  localparam logic [63:0] ERR_WORD = '1;
endpackage

// File: rtl/flash_rr_arbiter.sv
// flash_rr_arbiter: picks the first pending channel at or after the round-robin pointer
module flash_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PW = 1
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [PW-1:0]     idx,
  output logic              valid
);
  int c;
  always_comb begin
    grant = '0;
    idx = '0;
    valid = 1'b0;
    c = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (int'(ptr) + i) % NUM_CH;
      if (!valid && pending[c]) begin
        valid = 1'b1;
        idx = PW'(c);
        grant[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/flash_request_arbiter.sv
// flash_request_arbiter: multi-channel request capture and round-robin front end for the QSPI flash core
module flash_request_arbiter
  import flash_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_LSB = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [NUM_CH-1:0]          i_select,
  input  logic [NUM_CH-1:0]          i_cfg_select,
  input  logic [NUM_CH-1:0]          i_read_rq,
  input  logic [NUM_CH-1:0]          i_write_rq,
  input  logic [NUM_CH*ADDR_W-1:0]   i_address,
  input  logic [NUM_CH*DATA_W-1:0]   i_data,
  output logic [NUM_CH-1:0]          o_ack,
  output logic [NUM_CH-1:0]          o_error,
  output logic [NUM_CH-1:0]          o_busy,
  output logic [NUM_CH-1:0]          o_overrun,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic                       o_cfg_stb,
  output logic                       o_wb_we,
  output logic [ADDR_W-ADDR_LSB-1:0] o_wb_addr,
  output logic [DATA_W-1:0]          o_wb_data,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_stall,
  input  logic [DATA_W-1:0]          i_wb_data
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int WA = ADDR_W - ADDR_LSB;
  state_t state;
  logic [NUM_CH-1:0] pending, slot_we, slot_cfg, rq, cap, arb_grant, g_oh;
  logic [NUM_CH-1:0][WA-1:0] slot_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] slot_data;
  logic [PW-1:0] ptr, arb_idx, g;
  logic [CW-1:0] cnt;
  logic arb_valid, ack_now, expire, unused;
  assign rq = (i_read_rq | i_write_rq) & (i_select | i_cfg_select);
  assign cap = rq & ~pending;
  assign ack_now = i_wb_ack && (state == ST_WAIT || (state == ST_REQ && !i_wb_stall));
  assign expire = TIMEOUT != 0 && state != ST_IDLE && cnt >= CW'(TIMEOUT - 1);
  assign o_busy = pending;
  assign unused = ^i_address;
  flash_rr_arbiter #(.NUM_CH(NUM_CH), .PW(PW)) u_arb (
    .pending(pending),
    .ptr(ptr),
    .grant(arb_grant),
    .idx(arb_idx),
    .valid(arb_valid)
  );
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      pending <= '0;
      slot_we <= '0;
      slot_cfg <= '0;
      slot_addr <= '0;
      slot_data <= '0;
      ptr <= '0;
      g <= '0;
      g_oh <= '0;
      cnt <= '0;
      o_ack <= '0;
      o_error <= '0;
      o_overrun <= '0;
      o_data <= '0;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_cfg_stb <= 1'b0;
      o_wb_we <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
    end else begin
      o_ack <= '0;
      o_error <= '0;
      o_overrun <= rq & pending;
      pending <= pending | cap;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap[c]) begin
          slot_addr[c] <= i_address[c*ADDR_W+ADDR_LSB +: WA];
          slot_data[c] <= i_data[c*DATA_W +: DATA_W];
          slot_we[c] <= i_write_rq[c] ? WB_WRITE : WB_READ;
          slot_cfg[c] <= i_cfg_select[c] & ~i_select[c];
        end
      end
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            g <= arb_idx;
            g_oh <= arb_grant;
            cnt <= CW'(1);
            o_wb_cyc <= 1'b1;
            o_wb_stb <= !slot_cfg[arb_idx];
            o_cfg_stb <= slot_cfg[arb_idx];
            o_wb_we <= slot_we[arb_idx];
            o_wb_addr <= slot_addr[arb_idx];
            o_wb_data <= slot_data[arb_idx];
            state <= ST_REQ;
          end
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (ack_now || expire) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_cfg_stb <= 1'b0;
            o_ack <= g_oh;
            o_error <= ack_now ? '0 : g_oh;
            o_data <= ack_now ? i_wb_data : ERR_WORD[DATA_W-1:0];
            pending <= (pending | cap) & ~g_oh;
            ptr <= (g == PW'(NUM_CH - 1)) ? '0 : g + 1'b1;
            state <= ST_IDLE;
          end else if (state == ST_REQ && !i_wb_stall) begin
            o_wb_stb <= 1'b0;
            o_cfg_stb <= 1'b0;
            state <= ST_WAIT;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flash_request_arbiter.sv
// tb_flash_request_arbiter: randomized core/requester stimulus checked against a cycle-numbered transaction model
module tb_flash_request_arbiter;
  localparam int N = 2, AW = 32, DW = 32, LSB = 1, TO = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] sel, cfgsel, rd, wr, ack, err, busy, ov;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdat;
  logic [DW-1:0] rdata, wb_wdata, wb_rdata;
  logic cyc, stb, cstb, we, wb_ack, wb_stall;
  logic [AW-LSB-1:0] wb_addr;
  flash_request_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ADDR_LSB(LSB), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_select(sel), .i_cfg_select(cfgsel),
    .i_read_rq(rd), .i_write_rq(wr), .i_address(addr), .i_data(wdat),
    .o_ack(ack), .o_error(err), .o_busy(busy), .o_overrun(ov), .o_data(rdata),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_cfg_stb(cstb), .o_wb_we(we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata)
  );
  always #5 clk = ~clk;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; logic w; logic c;} req_t;
  req_t slot [N];
  logic [N-1:0] pend, e_ack, e_err, e_ov;
  logic [DW-1:0] e_data, core_data;
  int ptr, phase, g, grant_cyc, cyc_n, ack_at;
  int stall_pct, never_pct, fixed_delay, stall_hold;
  logic fix_data;
  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h cycle=%0d", tag, got, want, cyc_n);
    end
  endtask
  task automatic model_reset();
    pend = '0; ptr = 0; phase = 0; g = 0; grant_cyc = 0; ack_at = -1;
    e_ack = '0; e_err = '0; e_ov = '0; e_data = '0;
  endtask
  task automatic clear_rq();
    sel = '0; cfgsel = '0; rd = '0; wr = '0;
  endtask
  task automatic req(input int c, input logic w, input logic s, input logic cs, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sel[c] = s; cfgsel[c] = cs; wr[c] = w; rd[c] = !w;
    addr[c*AW +: AW] = a;
    wdat[c*DW +: DW] = d;
  endtask
  task automatic model_step();
    logic [N-1:0] rq, np;
    logic done, expire;
    rq = (rd | wr) & (sel | cfgsel);
    np = pend;
    e_ack = '0; e_err = '0; e_ov = rq & pend;
    if (phase == 0) begin
      for (int i = N - 1; i >= 0; i--) if (pend[(ptr + i) % N]) g = (ptr + i) % N;
      if (|pend) begin phase = 1; grant_cyc = cyc_n - 1; end
    end else begin
      done = wb_ack && (phase == 2 || !wb_stall);
      expire = (cyc_n - 1 - grant_cyc) >= TO - 1;
      if (done || expire) begin
        e_ack[g] = 1'b1; e_err[g] = !done;
        e_data = done ? wb_rdata : '1;
        np[g] = 1'b0; ptr = (g + 1) % N; phase = 0;
      end else if (phase == 1 && !wb_stall) phase = 2;
    end
    for (int c = 0; c < N; c++) begin
      if (rq[c] && !pend[c]) begin
        np[c] = 1'b1;
        slot[c].a = addr[c*AW +: AW];
        slot[c].d = wdat[c*DW +: DW];
        slot[c].w = wr[c];
        slot[c].c = cfgsel[c] && !sel[c];
      end
    end
    pend = np;
  endtask
  task automatic compare();
    check("busy", busy, pend);
    check("overrun", ov, e_ov);
    check("ack", ack, e_ack);
    check("error", err, e_err);
    check("cyc", cyc, phase != 0);
    check("stb", stb, phase == 1 && !slot[g].c);
    check("cfg_stb", cstb, phase == 1 && slot[g].c);
    if (phase == 1) begin
      check("addr", wb_addr, slot[g].a[AW-1:LSB]);
      check("wdata", wb_wdata, slot[g].d);
      check("we", we, slot[g].w);
    end
    if (|e_ack) check("rdata", rdata, e_data);
  endtask
  task automatic core_drive();
    int d;
    wb_ack = 1'b0;
    if (!cyc) ack_at = -1;
    if (ack_at == cyc_n) begin wb_ack = 1'b1; ack_at = -1; end
    wb_stall = $urandom_range(1);
    wb_rdata = fix_data ? core_data : $urandom;
    if (stb || cstb) begin
      if (stall_hold > 0) begin wb_stall = 1'b1; stall_hold--; end
      else wb_stall = int'($urandom_range(99)) < stall_pct;
      if (!wb_stall && int'($urandom_range(99)) >= never_pct) begin
        d = fixed_delay >= 0 ? fixed_delay : int'($urandom_range(4));
        if (d == 0) wb_ack = 1'b1;
        else ack_at = cyc_n + d;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
    model_step();
    compare();
    core_drive();
    clear_rq();
  endtask
  task automatic wait_ack(input string tag, input logic [N-1:0] want, output int n);
    n = 0;
    do begin step(); n++; end while (!(|ack) && n < 80);
    check(tag, ack, want);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] r, s;
    int n;
    clear_rq();
    addr = '0; wdat = '0; wb_ack = 1'b0; wb_stall = 1'b0; wb_rdata = '0;
    cyc_n = 0; fix_data = 1'b0; core_data = '0;
    stall_pct = 0; never_pct = 0; fixed_delay = 3; stall_hold = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0); check("rst_error", err, 0); check("rst_busy", busy, 0);
    check("rst_overrun", ov, 0); check("rst_data", rdata, 0); check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0); check("rst_cfg_stb", cstb, 0); check("rst_we", we, 0);
    check("rst_addr", wb_addr, 0); check("rst_wdata", wb_wdata, 0);
    rst_n = 1'b1;
    fix_data = 1'b1; core_data = 32'hDEAD_BEEF;
    step();
    req(0, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0);
    step(); step();
    check("t1_stb", stb, 1); check("t1_addr", wb_addr, 'h82); check("t1_we", we, 0);
    wait_ack("t1_ack", 2'b01, n);
    check("t1_latency", n, 4); check("t1_data", rdata, 32'hDEAD_BEEF);
    fix_data = 1'b0; fixed_delay = 1; stall_hold = 5;
    req(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678);
    wait_ack("t2_ack", 2'b10, n);
    check("t2_latency", n, 9);
    fixed_delay = -1;
    req(0, 1'b0, 1'b1, 1'b0, $urandom, $urandom);
    req(1, 1'b1, 1'b1, 1'b0, $urandom, $urandom);
    wait_ack("t3a_first", 2'b01, n);
    wait_ack("t3a_second", 2'b10, n);
    req(0, 1'b0, 1'b1, 1'b0, $urandom, $urandom);
    wait_ack("t3_single", 2'b01, n);
    req(0, 1'b1, 1'b1, 1'b0, $urandom, $urandom);
    req(1, 1'b0, 1'b1, 1'b0, $urandom, $urandom);
    wait_ack("t3b_first", 2'b10, n);
    wait_ack("t3b_second", 2'b01, n);
    fixed_delay = 4;
    req(0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    step();
    check("t4_busy", busy[0], 1);
    req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0F00, 32'hAAAA_5555);
    step();
    check("t4_overrun", ov[0], 1);
    wait_ack("t4_ack", 2'b01, n);
    repeat (4) step();
    check("t4_idle", cyc, 0);
    never_pct = 100; fixed_delay = -1;
    req(0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    wait_ack("t5_ack", 2'b01, n);
    check("t5_latency", n, 17); check("t5_error", err, 2'b01); check("t5_data", rdata, 32'hFFFF_FFFF);
    never_pct = 0;
    req(0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    wait_ack("t5_next_ack", 2'b01, n);
    check("t5_next_error", err, 0);
    stall_pct = 30; never_pct = 3;
    for (int k = 0; k < 1500; k++) begin
      step();
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(99) < 20) begin
          r = 2'($urandom_range(1, 3));
          s = 2'($urandom_range(3));
          sel[c] = s[0]; cfgsel[c] = s[1]; rd[c] = r[0]; wr[c] = r[1];
          addr[c*AW +: AW] = $urandom;
          wdat[c*DW +: DW] = $urandom;
        end
      end
    end
    n = 0;
    while ((phase != 0 || pend != 0) && n < 300) begin step(); n++; end
    check("drain", {pend, 8'(phase)}, 0);
    stall_pct = 0; never_pct = 0; fixed_delay = 12;
    req(0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0);
    step(); step();
    check("t6_cfg_stb", cstb, 1); check("t6_stb", stb, 0);
    step(); step();
    check("t6_wait_cyc", cyc, 1);
    rst_n = 1'b0;
    clear_rq();
    wb_ack = 1'b0; wb_stall = 1'b0;
    #1;
    check("t6_rst_cyc", cyc, 0); check("t6_rst_ack", ack, 0); check("t6_rst_busy", busy, 0);
    check("t6_rst_cfg_stb", cstb, 0); check("t6_rst_error", err, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
